// File: rtl/pipe_shifter_if.sv
// Valid/ready handshake bundle for pipe_shifter: operation in, result out.
// The slave modport is the shifter's view; master is the issuing/consuming side.
interface pipe_shifter_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TAG_W = 4
);
   localparam int unsigned SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [1:0]       in_op;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_tag
   );
endinterface

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL); stage k applies the 2^k step of the amount.
// One global enable advances or freezes every stage together.
module pipe_shifter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TAG_W = 4
) (
   input logic           clk,
   input logic           rst,
   pipe_shifter_if.slave bus
);
   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      OpSll = 2'b00,
      OpSrl = 2'b01,
      OpSra = 2'b10,
      OpRol = 2'b11
   } op_e;

   logic             en;
   logic [SHW-1:0]   valid_q, valid_d;
   logic [WIDTH-1:0] data_q [SHW];
   logic [WIDTH-1:0] data_d [SHW];
   logic [TAG_W-1:0] tag_q  [SHW];
   logic [TAG_W-1:0] tag_d  [SHW];
   // Control only travels as far as the last stage that still consumes it.
   logic [SHW-2:0]   rem_q  [SHW-1];
   logic [SHW-2:0]   rem_d  [SHW-1];
   op_e              op_q   [SHW-1];
   op_e              op_d   [SHW-1];
   logic [SHW-2:0]   sign_q, sign_d;

   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] d,
      input op_e              op,
      input logic             sign,
      input int unsigned      k,
      input logic             apply
   );
      logic [WIDTH-1:0] r;
      int unsigned      s;
      s = 32'd1 << k;
      unique case (op)
         OpSll:   r = d << s;
         OpSrl:   r = d >> s;
         OpSra:   r = (d >> s) | (sign ? ~({WIDTH{1'b1}} >> s) : '0);
         OpRol:   r = (d << s) | (d >> (WIDTH - s));
         default: r = d;
      endcase
      return apply ? r : d;
   endfunction

   always_comb begin
      en      = !valid_q[SHW-1] || bus.out_ready;
      valid_d = valid_q;
      data_d  = data_q;
      tag_d   = tag_q;
      rem_d   = rem_q;
      op_d    = op_q;
      sign_d  = sign_q;
      if (en) begin
         valid_d = {valid_q[SHW-2:0], bus.in_valid};
         // Payload is sampled only on acceptance; a bubble leaves stage 0 data untouched.
         if (bus.in_valid) begin
            data_d[0] = shift_step(bus.in_data, op_e'(bus.in_op), bus.in_data[WIDTH-1], 0,
                                   bus.in_amt[0]);
            tag_d[0]  = bus.in_tag;
            rem_d[0]  = bus.in_amt[SHW-1:1];
            op_d[0]   = op_e'(bus.in_op);
            sign_d[0] = bus.in_data[WIDTH-1];
         end
         for (int unsigned k = 1; k < SHW; k++) begin
            data_d[k] = shift_step(data_q[k-1], op_q[k-1], sign_q[k-1], k, rem_q[k-1][0]);
            tag_d[k]  = tag_q[k-1];
         end
         for (int unsigned k = 1; k < SHW - 1; k++) begin
            rem_d[k]  = rem_q[k-1] >> 1;
            op_d[k]   = op_q[k-1];
            sign_d[k] = sign_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         sign_q  <= '0;
         for (int unsigned k = 0; k < SHW; k++) begin
            data_q[k] <= '0;
            tag_q[k]  <= '0;
         end
         for (int unsigned k = 0; k < SHW - 1; k++) begin
            rem_q[k] <= '0;
            op_q[k]  <= OpSll;
         end
      end else begin
         valid_q <= valid_d;
         sign_q  <= sign_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = valid_q[SHW-1];
   assign bus.out_data  = data_q[SHW-1];
   assign bus.out_zero  = (data_q[SHW-1] == '0);
   assign bus.out_tag   = tag_q[SHW-1];
endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter at WIDTH 16, 8 and 32: issued ops push expected results,
// a negedge monitor pops and compares them, and checks stall stability and latency.
module tb_pipe_shifter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_shifter_if #(.WIDTH(16), .TAG_W(4)) b16 ();
   pipe_shifter_if #(.WIDTH(8),  .TAG_W(4)) b8 ();
   pipe_shifter_if #(.WIDTH(32), .TAG_W(4)) b32 ();

   pipe_shifter #(.WIDTH(16), .TAG_W(4)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));
   pipe_shifter #(.WIDTH(8),  .TAG_W(4)) u_dut8  (.clk(clk), .rst(rst), .bus(b8));
   pipe_shifter #(.WIDTH(32), .TAG_W(4)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));

   logic        iv [3];
   logic [63:0] id [3];
   logic [5:0]  ia [3];
   logic [1:0]  io [3];
   logic [3:0]  it [3];
   logic        ordy [3];
   logic        irdy [3];
   logic        ov [3];
   logic        oz [3];
   logic [63:0] od [3];
   logic [3:0]  ot [3];

   assign b16.in_valid  = iv[0];
   assign b16.in_data   = id[0][15:0];
   assign b16.in_amt    = ia[0][3:0];
   assign b16.in_op     = io[0];
   assign b16.in_tag    = it[0];
   assign b16.out_ready = ordy[0];
   assign irdy[0] = b16.in_ready;
   assign ov[0]   = b16.out_valid;
   assign oz[0]   = b16.out_zero;
   assign od[0]   = {48'd0, b16.out_data};
   assign ot[0]   = b16.out_tag;

   assign b8.in_valid  = iv[1];
   assign b8.in_data   = id[1][7:0];
   assign b8.in_amt    = ia[1][2:0];
   assign b8.in_op     = io[1];
   assign b8.in_tag    = it[1];
   assign b8.out_ready = ordy[1];
   assign irdy[1] = b8.in_ready;
   assign ov[1]   = b8.out_valid;
   assign oz[1]   = b8.out_zero;
   assign od[1]   = {56'd0, b8.out_data};
   assign ot[1]   = b8.out_tag;

   assign b32.in_valid  = iv[2];
   assign b32.in_data   = id[2][31:0];
   assign b32.in_amt    = ia[2][4:0];
   assign b32.in_op     = io[2];
   assign b32.in_tag    = it[2];
   assign b32.out_ready = ordy[2];
   assign irdy[2] = b32.in_ready;
   assign ov[2]   = b32.out_valid;
   assign oz[2]   = b32.out_zero;
   assign od[2]   = {32'd0, b32.out_data};
   assign ot[2]   = b32.out_tag;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  tag;
      int          cyc;
      bit          lc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wid(input int u);
      return (u == 0) ? 16 : ((u == 1) ? 8 : 32);
   endfunction

   function automatic int lat(input int u);
      return (u == 0) ? 4 : ((u == 1) ? 3 : 5);
   endfunction

   function automatic logic [63:0] mask(input int u);
      return (64'd1 << wid(u)) - 64'd1;
   endfunction

   // Bit-by-bit definition of each op: result bit i comes from source bit i -/+ amount.
   function automatic logic [63:0] ref_shift(input logic [63:0] d, input int w, input int a,
                                             input logic [1:0] op);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (op)
            2'b00:   r[i] = (i >= a) ? d[i-a] : 1'b0;
            2'b01:   r[i] = (i + a < w) ? d[i+a] : 1'b0;
            2'b10:   r[i] = (i + a < w) ? d[i+a] : d[w-1];
            default: r[i] = d[(i - a + w) % w];
         endcase
      end
      return r;
   endfunction

   function automatic int qsize(input int u);
      case (u)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic push(input int u, input exp_t e);
      case (u)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pop(input int u, output exp_t e);
      case (u)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   // Monitor: scoreboard pops on retirement, plus stall-stability and in_ready rules.
   logic        stall_p [3];
   logic [63:0] pd [3];
   logic [3:0]  pt [3];
   always @(negedge clk) begin
      for (int u = 0; u < 3; u++) begin
         if (rst) begin
            stall_p[u] = 1'b0;
         end else begin
            exp_t e;
            if (stall_p[u]) begin
               chk($sformatf("u%0d_stall_valid", u), 64'(ov[u]), 64'd1);
               chk($sformatf("u%0d_stall_data", u), od[u], pd[u]);
               chk($sformatf("u%0d_stall_tag", u), 64'(ot[u]), 64'(pt[u]));
            end
            if (ov[u] && !ordy[u]) chk($sformatf("u%0d_stall_in_ready", u), 64'(irdy[u]), 64'd0);
            if (!ov[u]) chk($sformatf("u%0d_idle_in_ready", u), 64'(irdy[u]), 64'd1);
            if (ov[u] && ordy[u]) begin
               if (qsize(u) == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL u%0d_unexpected_result: got data 0x%0h tag %0d, want none",
                           u, od[u], ot[u]);
               end else begin
                  pop(u, e);
                  chk($sformatf("u%0d_data tag%0d", u, e.tag), od[u], e.data);
                  chk($sformatf("u%0d_tag", u), 64'(ot[u]), 64'(e.tag));
                  chk($sformatf("u%0d_zero", u), 64'(oz[u]), 64'(e.data == 64'd0));
                  if (e.lc) chk($sformatf("u%0d_latency", u), 64'(cyc - e.cyc), 64'(lat(u)));
               end
            end
            stall_p[u] = ov[u] && !ordy[u];
            pd[u] = od[u];
            pt[u] = ot[u];
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input int u, input logic [63:0] d, input int a, input logic [1:0] op,
                        input logic [3:0] tag, input logic [63:0] e, input bit lc);
      exp_t x;
      int   n;
      iv[u] = 1'b1;
      id[u] = d;
      ia[u] = 6'(a);
      io[u] = op;
      it[u] = tag;
      n = 0;
      forever begin
         @(negedge clk);
         if (irdy[u]) begin
            x.data = e;
            x.tag  = tag;
            x.cyc  = cyc;
            x.lc   = lc;
            push(u, x);
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
         n++;
         if (n > 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL u%0d_issue_timeout: got in_ready=0 for %0d cycles, want acceptance",
                     u, n);
            break;
         end
      end
   endtask

   task automatic issue_rand(input int u, input logic [3:0] tag, input bit lc);
      logic [63:0] d;
      int          a;
      logic [1:0]  op;
      d  = {$urandom, $urandom} & mask(u);
      a  = int'($urandom_range(0, wid(u) - 1));
      op = 2'($urandom_range(0, 3));
      issue(u, d, a, op, tag, ref_shift(d, wid(u), a, op), lc);
   endtask

   task automatic drain(input int u);
      int n;
      iv[u] = 1'b0;
      n = 0;
      while (qsize(u) != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("u%0d_drain_pending", u), 64'(qsize(u)), 64'd0);
   endtask

   logic [63:0] pat;
   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int u = 0; u < 3; u++) begin
         iv[u] = 1'b0; id[u] = '0; ia[u] = '0; io[u] = '0; it[u] = '0; ordy[u] = 1'b1;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("u%0d_rst_valid", u), 64'(ov[u]), 64'd0);
         chk($sformatf("u%0d_rst_data", u), od[u], 64'd0);
         chk($sformatf("u%0d_rst_zero", u), 64'(oz[u]), 64'd1);
         chk($sformatf("u%0d_rst_tag", u), 64'(ot[u]), 64'd0);
         chk($sformatf("u%0d_rst_in_ready", u), 64'(irdy[u]), 64'd1);
      end
      @(posedge clk);
      #1;

      // Directed cases, expected values taken straight from the op definitions.
      issue(0, 64'h00FF, 4,  2'b00, 4'd1, 64'h0FF0, 1'b1);
      issue(0, 64'h8000, 15, 2'b01, 4'd2, 64'h0001, 1'b1);
      issue(0, 64'h8001, 1,  2'b10, 4'd3, 64'hC000, 1'b1);
      issue(0, 64'h8001, 1,  2'b11, 4'd4, 64'h0003, 1'b1);
      issue(0, 64'h1234, 0,  2'b00, 4'd5, 64'h1234, 1'b1);
      issue(0, 64'h0001, 1,  2'b01, 4'd6, 64'h0000, 1'b1);
      issue(0, 64'hA5A5, 0,  2'b11, 4'd7, 64'hA5A5, 1'b1);
      drain(0);

      for (int t = 0; t < 16; t++) issue_rand(0, 4'(t), 1'b1);
      drain(0);

      fork
         begin
            for (int t = 0; t < 24; t++) issue_rand(0, 4'(t), 1'b0);
            iv[0] = 1'b0;
         end
         begin
            repeat (8) @(posedge clk);
            #1;
            ordy[0] = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            ordy[0] = 1'b1;
         end
      join
      drain(0);

      fork
         begin
            for (int t = 0; t < 40; t++) issue_rand(0, 4'(t), 1'b0);
            iv[0] = 1'b0;
         end
         begin
            repeat (80) begin
               @(posedge clk);
               #1;
               ordy[0] = 1'($urandom_range(0, 1));
            end
            ordy[0] = 1'b1;
         end
      join
      drain(0);

      for (int t = 0; t < 3; t++) issue_rand(0, 4'(t + 8), 1'b0);
      iv[0] = 1'b0;
      rst = 1'b1;
      q0.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("u0_midrst_valid", 64'(ov[0]), 64'd0);
      chk("u0_midrst_data", od[0], 64'd0);
      chk("u0_midrst_zero", 64'(oz[0]), 64'd1);
      chk("u0_midrst_in_ready", 64'(irdy[0]), 64'd1);
      repeat (10) @(posedge clk);
      #1;

      for (int u = 0; u < 3; u++) begin
         for (int op = 0; op < 4; op++) begin
            for (int p = 0; p < 3; p++) begin
               pat = 64'h5555_5555_5555_5555;
               if (p == 0) pat = 64'd1 << (wid(u) - 1);
               else if (p == 1) pat = pat & mask(u);
               else pat = mask(u);
               for (int a = 0; a < wid(u); a++) begin
                  issue(u, pat, a, 2'(op), 4'($urandom_range(0, 15)),
                        ref_shift(pat, wid(u), a, 2'(op)), 1'b1);
               end
            end
         end
         drain(u);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_shifter.md
# pipe_shifter

Parametrised, pipelined barrel shifter that replaces the single-cycle 16-bit left shifter in the datapath. It performs logical-left, logical-right, arithmetic-right and rotate-left operations on a WIDTH-bit operand by any amount 0..WIDTH-1. The block uses a log2(WIDTH)-stage pipeline with valid/ready handshakes on both sides, so it sits between the decode/operand-fetch stage and writeback. A tag travels with each operation so the issuing logic can match results to destination registers.

## Interface
- WIDTH, 16: operand width; power of two, 4..64.
- SHW, $clog2(WIDTH): derived, not overridden; shift-amount width and pipeline depth.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented this cycle.
- in_ready  output  1  block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag  input  TAG_W  opaque sideband, returned unchanged.
- out_valid  output  1  result held on out_* this cycle.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0.
- out_tag  output  TAG_W  tag of this result.

## Operation
- Stage k (k = 0..SHW-1) conditionally shifts or rotates by 2^k when bit k of the amount is set, then registers data, the remaining amount bits, op, tag and a valid bit.
- SLL fills with 0 from the LSB. SRL fills with 0 from the MSB. SRA fills with the operand's original bit WIDTH-1, which travels with the operation through the pipeline. ROL moves bits shifted out of the MSB back in at the LSB.
- An amount of 0 passes the operand through unchanged for every op.
- out_zero is computed combinationally from the final-stage data register.
- Global advance: en = !out_valid || out_ready. All stage registers, including valid bits, load only when en=1 and hold otherwise. in_ready = en.
- An operation is accepted when in_valid && in_ready. When en=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Bubbles are not compressed. A stall freezes the whole pipe.
- Results leave in issue order. No operation is ever dropped or duplicated.
- The block has no error conditions. All op/amt combinations are legal.

## Timing
- Reset (rst=1 at a clock edge):
  - All stage valid bits clear, so out_valid=0 on the next cycle.
  - Stage data, tag, op and amount registers clear to 0, so out_data=0, out_tag=0 and out_zero=1.
  - in_ready=1 from the first cycle after reset.
  - Reset takes priority over en. In-flight operations are discarded with no output.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+SHW-1, i.e. SHW cycles later (4 for WIDTH=16), provided there are no stalls.
- Throughput: one operation per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_* stay stable and in_ready=0. Input is accepted again in the same cycle out_ready rises.
- Simultaneous events: when out_ready=1 with out_valid=1 and in_valid=1, the result retires and the new operation enters in the same cycle.
- When out_valid=0, in_ready=1 regardless of out_ready.
- in_data, in_amt, in_op and in_tag are sampled only on acceptance. They are don't-care otherwise.

## Test plan
- Basic ops, WIDTH=16, out_ready=1:
  - SLL 0x00FF by 4 → 0x0FF0.
  - SRL 0x8000 by 15 → 0x0001.
  - SRA 0x8001 by 1 → 0xC000.
  - ROL 0x8001 by 1 → 0x0003.
  - Each result appears exactly 4 cycles after acceptance, with its tag intact.
- Zero/identity:
  - SLL 0x1234 by 0 → 0x1234, out_zero=0.
  - SRL 0x0001 by 1 → 0x0000, out_zero=1.
  - ROL 0xA5A5 by 0 → 0xA5A5.
- Streaming: issue 16 back-to-back ops with tags 0..15 and random op/amt → 16 results in tag order on 16 consecutive cycles, each matching a reference model.
- Backpressure:
  - Stream with out_ready held 0 for 5 cycles mid-run → out_* are stable and in_ready=0 throughout.
  - After out_ready returns, there is no loss or duplication and order is preserved.
- Reset mid-operation: accept 3 ops, then assert rst for 1 cycle → out_valid=0 and out_data=0 after reset, none of the 3 results ever appear, and in_ready=1 the next cycle.
- Parameter sweep: WIDTH=8 and WIDTH=32, exhaustive amounts for all 4 ops on operands 0x80…0, 0x55…5 and all-ones → results match the reference model, with latency 3 and 5 cycles respectively.
